tilt_motion_encoder: RTL and testbench

- Converts raw signed accelerometer samples into the per-axis motion commands the hardware ball consumes: x/y increment, x/y decrement and 8-bit x/y threshold.
- Averages a block of samples, applies a deadband, and scales the remaining tilt into an 8-bit magnitude.
- Sits between the accelerometer sample interface and the ball position block. It is the producer side of that command interface.

---
 rtl/tilt_pkg.sv | 21 ++
 rtl/tilt_axis_shaper.sv | 108 ++++++++++
 rtl/tilt_motion_encoder.sv | 128 ++++++++++++
 tb/tb_tilt_motion_encoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tilt_pkg.sv
// Shared types and constants for the tilt motion encoder.
// Optional hysteresis is enabled with TILT_HYSTERESIS_EN.
package tilt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SCALE,
    UPDATE
  } tilt_state_e;

  localparam logic [7:0] THR_SAT = 8'd255;
  localparam logic [7:0] THR_MIN = 8'd1;

  typedef struct packed {
    logic       inc;
    logic       dec;
    logic [7:0] thr;
  } axis_cmd_t;

endpackage

// File: rtl/tilt_axis_shaper.sv
// Per-axis accumulate, average, deadband and magnitude scaling.
// TILT_HYSTERESIS_EN adds a sticky moving flag with a half deadband.
module tilt_axis_shaper
  import tilt_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int AVG_LOG2     = 2,
  parameter int DEADBAND     = 31,
  parameter int MAG_SHIFT    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           load,
  input  logic                           accum,
  input  logic                           scale,
  input  logic                           update,
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output axis_cmd_t                      cmd
);

  localparam int AW = SAMPLE_WIDTH + AVG_LOG2;
  localparam int MW = SAMPLE_WIDTH + 1;
  localparam logic [MW-1:0] DB = MW'(DEADBAND);

  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] avg;
  logic signed [MW-1:0] avg_w;
  logic [MW-1:0]        mag_d;
  logic [MW-1:0]        mag_q;
  logic                 pos_d;
  logic                 pos_q;
  logic [MW-1:0]        excess;
  logic [MW-1:0]        shifted;
  logic [7:0]           thr_scaled;
  logic                 beyond;
  logic                 live;
  axis_cmd_t            cmd_d;

  assign ext   = AW'(sample);
  assign avg   = acc_q >>> AVG_LOG2;
  // avg always fits in SAMPLE_WIDTH bits; one extra bit keeps |min| positive
  assign avg_w = MW'(avg);
  assign mag_d = avg_w[MW-1] ? $unsigned(-avg_w) : $unsigned(avg_w);
  assign pos_d = !avg_w[MW-1] && (avg_w != '0);

  assign excess  = mag_q - DB;
  assign shifted = excess >> MAG_SHIFT;
  assign beyond  = mag_q > DB;

  always_comb begin
    thr_scaled = shifted[7:0];
    if (shifted > MW'(THR_SAT))
      thr_scaled = THR_SAT;
    else if (shifted[7:0] == 8'd0)
      thr_scaled = THR_MIN;
  end

`ifdef TILT_HYSTERESIS_EN
  localparam logic [MW-1:0] DBH = MW'(DEADBAND >> 1);
  logic moving_q;
  logic zero_q;
  assign live = beyond ||
                (moving_q && (mag_q > DBH) && !zero_q);
`else
  assign live = beyond;
`endif

  always_comb begin
    cmd_d     = '0;
    cmd_d.inc = live && pos_q;
    cmd_d.dec = live && !pos_q;
    if (live)
      cmd_d.thr = beyond ? thr_scaled : THR_MIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mag_q    <= '0;
      pos_q    <= 1'b0;
      cmd      <= '0;
`ifdef TILT_HYSTERESIS_EN
      moving_q <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      if (load)
        acc_q <= ext;
      else if (accum)
        acc_q <= acc_q + ext;
      if (scale) begin
        mag_q  <= mag_d;
        pos_q  <= pos_d;
`ifdef TILT_HYSTERESIS_EN
        zero_q <= (avg_w == '0);
`endif
      end
      if (update) begin
        cmd      <= cmd_d;
`ifdef TILT_HYSTERESIS_EN
        moving_q <= live;
`endif
      end
    end
  end

endmodule

// File: rtl/tilt_motion_encoder.sv
// Accelerometer block averager driving ball x/y motion commands.
// Define TILT_HYSTERESIS_EN for per-axis motion hysteresis.
module tilt_motion_encoder
  import tilt_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 12,
  parameter int AVG_LOG2     = 2,
  parameter int DEADBAND     = 31,
  parameter int MAG_SHIFT    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_x,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_y,
  output logic                           x_increment,
  output logic                           x_decrement,
  output logic                           y_increment,
  output logic                           y_decrement,
  output logic [7:0]                     x_threshold,
  output logic [7:0]                     y_threshold,
  output logic                           update_strobe
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  tilt_state_e   state_q;
  tilt_state_e   state_d;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic          strobe_q;
  logic          xfer;
  logic          load;
  logic          accum;
  logic          scale;
  logic          update;
  axis_cmd_t     x_cmd;
  axis_cmd_t     y_cmd;

  assign xfer   = sample_valid && ready_q;
  assign scale  = (state_q == SCALE);
  assign update = (state_q == UPDATE);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accum   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          state_d = (N == 1) ? SCALE : ACCUM;
        end
      end
      ACCUM: begin
        if (xfer) begin
          accum = 1'b1;
          if (cnt_q == CW'(N - 1))
            state_d = SCALE;
        end
      end
      SCALE:  state_d = UPDATE;
      UPDATE: state_d = IDLE;
    endcase
  end

  // ready is registered so it stays low for the whole reset assertion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == IDLE) || (state_d == ACCUM);
      strobe_q <= update;
      if (load)
        cnt_q <= CW'(1);
      else if (accum)
        cnt_q <= cnt_q + CW'(1);
    end
  end

  tilt_axis_shaper #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .AVG_LOG2    (AVG_LOG2),
    .DEADBAND    (DEADBAND),
    .MAG_SHIFT   (MAG_SHIFT)
  ) u_x (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .accum (accum),
    .scale (scale),
    .update(update),
    .sample(sample_x),
    .cmd   (x_cmd)
  );

  tilt_axis_shaper #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .AVG_LOG2    (AVG_LOG2),
    .DEADBAND    (DEADBAND),
    .MAG_SHIFT   (MAG_SHIFT)
  ) u_y (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .accum (accum),
    .scale (scale),
    .update(update),
    .sample(sample_y),
    .cmd   (y_cmd)
  );

  assign sample_ready  = ready_q;
  assign update_strobe = strobe_q;
  assign x_increment   = x_cmd.inc;
  assign x_decrement   = x_cmd.dec;
  assign x_threshold   = x_cmd.thr;
  assign y_increment   = y_cmd.inc;
  assign y_decrement   = y_cmd.dec;
  assign y_threshold   = y_cmd.thr;

endmodule

// File: tb/tb_tilt_motion_encoder.sv
// Directed bench for tilt_motion_encoder (default and MAG_SHIFT=0).
// Hysteresis expectations follow TILT_HYSTERESIS_EN.
module tb_tilt_motion_encoder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sample_valid = 1'b0;
  logic [11:0] sample_x = '0;
  logic [11:0] sample_y = '0;

  logic sample_ready, x_increment, x_decrement, y_increment, y_decrement;
  logic [7:0] x_threshold, y_threshold;
  logic update_strobe;

  logic z_ready, z_xi, z_xd, z_yi, z_yd, z_strobe;
  logic [7:0] z_xt, z_yt;

  logic [9:0] xv, yv, zv;
  assign xv = {x_increment, x_decrement, x_threshold};
  assign yv = {y_increment, y_decrement, y_threshold};
  assign zv = {z_xi, z_xd, z_xt};

  int cmp = 0;
  int bad = 0;
  int lat = 0;

  always #5 clk = ~clk;

  tilt_motion_encoder dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sample_x), .sample_y(sample_y),
    .x_increment(x_increment), .x_decrement(x_decrement),
    .y_increment(y_increment), .y_decrement(y_decrement),
    .x_threshold(x_threshold), .y_threshold(y_threshold),
    .update_strobe(update_strobe)
  );

  tilt_motion_encoder #(.MAG_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(z_ready),
    .sample_x(sample_x), .sample_y(sample_y),
    .x_increment(z_xi), .x_decrement(z_xd),
    .y_increment(z_yi), .y_decrement(z_yd),
    .x_threshold(z_xt), .y_threshold(z_yt),
    .update_strobe(z_strobe)
  );

  task automatic push(input int x, input int y);
    int n;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_x = 12'(x);
    sample_y = 12'(y);
    n = 0;
    while (!sample_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      cmp++; bad++;
      $display("FAIL push_timeout: ready got 0 want 1");
    end
    @(posedge clk);
  endtask

  task automatic wait_strobe();
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      sample_valid = 1'b0;
      lat++;
      if (update_strobe) break;
    end
  endtask

  task automatic run_block(input int x0, x1, x2, x3,
                           input int y0, y1, y2, y3);
    push(x0, y0);
    push(x1, y1);
    push(x2, y2);
    push(x3, y3);
    wait_strobe();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    cmp++;
    if (sample_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got %b want 0", sample_ready);
    end
    cmp++;
    if ({xv, yv, update_strobe} !== 21'd0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {xv, yv, update_strobe});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    cmp++;
    if (sample_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", sample_ready);
    end
  endtask

  task automatic test_basic();
    run_block(200, 200, 200, 200, -200, -200, -200, -200);
    cmp++;
    if (lat !== 3) begin
      bad++; $display("FAIL basic_latency: got %0d want 3", lat);
    end
    cmp++;
    if (xv !== {2'b10, 8'd21}) begin
      bad++; $display("FAIL basic_x: got %h want %h", xv, {2'b10, 8'd21});
    end
    cmp++;
    if (yv !== {2'b01, 8'd21}) begin
      bad++; $display("FAIL basic_y: got %h want %h", yv, {2'b01, 8'd21});
    end
    @(negedge clk);
    cmp++;
    if ({update_strobe, xv} !== {1'b0, 2'b10, 8'd21}) begin
      bad++; $display("FAIL basic_hold: got %h want %h", {update_strobe, xv},
                      {1'b0, 2'b10, 8'd21});
    end
  endtask

  task automatic test_deadband();
    run_block(31, 31, 31, 31, 0, 0, 0, 0);
    cmp++;
    if (xv !== 10'd0) begin
      bad++; $display("FAIL deadband_31: got %h want 0", xv);
    end
    run_block(32, 32, 32, 32, 0, 0, 0, 0);
    cmp++;
    if (xv !== {2'b10, 8'd1}) begin
      bad++; $display("FAIL deadband_32: got %h want %h", xv, {2'b10, 8'd1});
    end
    cmp++;
    if (yv !== 10'd0) begin
      bad++; $display("FAIL deadband_y_idle: got %h want 0", yv);
    end
  endtask

  task automatic test_saturation();
    run_block(-2048, -2048, -2048, -2048, 0, 0, 0, 0);
    cmp++;
    if (xv !== {2'b01, 8'd252}) begin
      bad++; $display("FAIL sat_shift3: got %h want %h", xv, {2'b01, 8'd252});
    end
    cmp++;
    if (zv !== {2'b01, 8'd255}) begin
      bad++; $display("FAIL sat_shift0: got %h want %h", zv, {2'b01, 8'd255});
    end
  endtask

  task automatic test_averaging();
    run_block(100, 100, -100, -100, 0, 0, 0, 0);
    cmp++;
    if (xv !== 10'd0) begin
      bad++; $display("FAIL avg_cancel: got %h want 0", xv);
    end
    run_block(0, 0, 0, 127, 0, 0, 0, 0);
    cmp++;
    if (xv !== 10'd0) begin
      bad++; $display("FAIL avg_floor31: got %h want 0", xv);
    end
    run_block(-1, 0, 0, 0, 0, 0, 0, 0);
    cmp++;
    if (xv !== 10'd0) begin
      bad++; $display("FAIL avg_neg1: got %h want 0", xv);
    end
  endtask

  task automatic test_hysteresis();
    logic [9:0] want;
    run_block(40, 40, 40, 40, 0, 0, 0, 0);
    cmp++;
    if (xv !== {2'b10, 8'd1}) begin
      bad++; $display("FAIL hyst_40: got %h want %h", xv, {2'b10, 8'd1});
    end
    run_block(20, 20, 20, 20, 0, 0, 0, 0);
`ifdef TILT_HYSTERESIS_EN
    want = {2'b10, 8'd1};
`else
    want = 10'd0;
`endif
    cmp++;
    if (xv !== want) begin
      bad++; $display("FAIL hyst_20: got %h want %h", xv, want);
    end
    run_block(15, 15, 15, 15, 0, 0, 0, 0);
    cmp++;
    if (xv !== 10'd0) begin
      bad++; $display("FAIL hyst_15: got %h want 0", xv);
    end
  endtask

  task automatic test_back_to_back();
    int xt[8] = '{100, 200, 300, 400, -40, -80, -120, -160};
    int yt[8] = '{-400, -400, -400, -400, 50, 50, 50, 50};
    logic [9:0] xo[2];
    logic [9:0] yo[2];
    int k, xfers, lows, strobes;
    logic go;
    k = 0; xfers = 0; lows = 0; strobes = 0;
    xo[0] = '0; xo[1] = '0; yo[0] = '0; yo[1] = '0;
    for (int cyc = 0; cyc < 60 && strobes < 2; cyc++) begin
      @(negedge clk);
      if (update_strobe) begin
        xo[strobes] = xv;
        yo[strobes] = yv;
        strobes++;
      end
      if (k < 8) begin
        sample_valid = 1'b1;
        sample_x = 12'(xt[k]);
        sample_y = 12'(yt[k]);
        if (!sample_ready) lows++;
      end else begin
        sample_valid = 1'b0;
      end
      go = sample_valid && sample_ready;
      @(posedge clk);
      if (go) begin
        k++;
        xfers++;
      end
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (update_strobe) strobes++;
    end
    cmp++;
    if (xfers !== 8) begin
      bad++; $display("FAIL b2b_xfers: got %0d want 8", xfers);
    end
    cmp++;
    if (lows !== 2) begin
      bad++; $display("FAIL b2b_ready_low: got %0d want 2", lows);
    end
    cmp++;
    if (strobes !== 2) begin
      bad++; $display("FAIL b2b_strobes: got %0d want 2", strobes);
    end
    cmp++;
    if ({xo[0], yo[0]} !== {2'b10, 8'd27, 2'b01, 8'd46}) begin
      bad++; $display("FAIL b2b_block1: got %h want %h", {xo[0], yo[0]},
                      {2'b10, 8'd27, 2'b01, 8'd46});
    end
    cmp++;
    if ({xo[1], yo[1]} !== {2'b01, 8'd8, 2'b10, 8'd2}) begin
      bad++; $display("FAIL b2b_block2: got %h want %h", {xo[1], yo[1]},
                      {2'b01, 8'd8, 2'b10, 8'd2});
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    push(-2048, 0);
    push(-2048, 0);
    @(negedge clk);
    sample_valid = 1'b0;
    reset = 1'b0;
    #1;
    cmp++;
    if ({xv, yv, update_strobe, sample_ready} !== 22'd0) begin
      bad++; $display("FAIL mid_reset_async: got %h want 0",
                      {xv, yv, update_strobe, sample_ready});
    end
    repeat (2) @(negedge clk);
    cmp++;
    if (sample_ready !== 1'b0) begin
      bad++; $display("FAIL mid_reset_ready: got %b want 0", sample_ready);
    end
    reset = 1'b1;
    push(200, 0);
    push(200, 0);
    push(200, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (update_strobe) seen++;
    end
    cmp++;
    if (seen !== 0) begin
      bad++; $display("FAIL mid_early_strobe: got %0d want 0", seen);
    end
    push(200, 0);
    wait_strobe();
    cmp++;
    if (lat !== 3) begin
      bad++; $display("FAIL mid_latency: got %0d want 3", lat);
    end
    cmp++;
    if (xv !== {2'b10, 8'd21}) begin
      bad++; $display("FAIL mid_fresh_x: got %h want %h", xv, {2'b10, 8'd21});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_deadband();
    test_saturation();
    test_averaging();
    test_hysteresis();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
